// File: rtl/alu_result_sel.sv
// Registered ALU result selector: decodes ALUOp to a functional unit at accept time,
// waits for that unit's valid (or a timeout) and holds the result for writeback.
//
// state  | meaning
// S_IDLE | no op in flight, ready to accept
// S_WAIT | op accepted, waiting for the selected unit's valid or timeout
// S_HOLD | result presented on dalja until writeback takes it
module alu_result_sel #(
  parameter int WIDTH   = 16,
  parameter int N_IN    = 4,
  parameter int OPW     = 4,
  parameter int SEL_W   = $clog2(N_IN),
  parameter logic [(2**OPW)*SEL_W-1:0] SEL_MAP = 32'h0000_E004,
  parameter int TIMEOUT = 16
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [N_IN*WIDTH-1:0] hyrja,
  input  logic [N_IN-1:0]       hyrja_valid,
  input  logic [OPW-1:0]        ALUOp,
  input  logic                  op_valid,
  output logic                  op_ready,
  output logic [WIDTH-1:0]      dalja,
  output logic                  dalja_valid,
  input  logic                  dalja_ready,
  output logic                  gabim
);

  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HOLD} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [SEL_W-1:0]   r_sel;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_dalja;
  logic               r_dalja_valid;
  logic               r_gabim;

  logic [SEL_W-1:0]   w_map;
  logic [SEL_W-1:0]   w_sel_dec;
  logic               w_unit_valid;
  logic [WIDTH-1:0]   w_unit_data;
  logic               w_timeout;
  logic               w_accept;

  // Out-of-range table entries fall back to unit 0.
  assign w_map        = SEL_MAP[ALUOp*SEL_W +: SEL_W];
  assign w_sel_dec    = (int'(w_map) < N_IN) ? w_map : '0;
  assign w_unit_valid = hyrja_valid[r_sel];
  assign w_unit_data  = hyrja[r_sel*WIDTH +: WIDTH];
  assign w_timeout    = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_WAIT;
      S_WAIT: if (w_unit_valid || w_timeout) w_state_nxt = S_HOLD;
      S_HOLD: if (dalja_ready) w_state_nxt = w_accept ? S_WAIT : S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    op_ready = (r_state == S_IDLE) || ((r_state == S_HOLD) && dalja_ready);
    w_accept = op_valid && op_ready;
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      r_sel         <= '0;
      r_cnt         <= '0;
      r_dalja       <= '0;
      r_dalja_valid <= 1'b0;
      r_gabim       <= 1'b0;
    end else begin
      if (w_accept) begin
        r_sel <= w_sel_dec;
        r_cnt <= '0;
      end
      if (r_state == S_WAIT) begin
        // A real result arriving on the last cycle beats the timeout.
        if (w_unit_valid) begin
          r_dalja       <= w_unit_data;
          r_gabim       <= 1'b0;
          r_dalja_valid <= 1'b1;
        end else begin
          if (r_cnt != '1) r_cnt <= r_cnt + CNT_W'(1);
          if (w_timeout) begin
            r_dalja       <= '0;
            r_gabim       <= 1'b1;
            r_dalja_valid <= 1'b1;
          end
        end
      end
      if ((r_state == S_HOLD) && dalja_ready) begin
        r_dalja_valid <= 1'b0;
      end
    end
  end

  assign dalja       = r_dalja;
  assign dalja_valid = r_dalja_valid;
  assign gabim       = r_gabim;

endmodule

// File: tb/tb_alu_result_sel.sv
// Directed bench for alu_result_sel: stimulus pushes expected results into a queue,
// a negedge monitor pops and compares every completed writeback handshake.
module tb_alu_result_sel;

  logic        Clock;
  logic        Reset;
  logic [63:0] hyrja;
  logic [3:0]  hyrja_valid;
  logic [3:0]  ALUOp;
  logic        op_valid;
  logic        op_ready;
  logic [15:0] dalja;
  logic        dalja_valid;
  logic        dalja_ready;
  logic        gabim;

  int n_cmp = 0;
  int n_err = 0;
  logic [16:0] q[$];

  alu_result_sel dut (
    .Clock(Clock), .Reset(Reset), .hyrja(hyrja), .hyrja_valid(hyrja_valid),
    .ALUOp(ALUOp), .op_valid(op_valid), .op_ready(op_ready), .dalja(dalja),
    .dalja_valid(dalja_valid), .dalja_ready(dalja_ready), .gabim(gabim)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge Clock);
    #1;
  endtask

  task automatic mid();
    @(negedge Clock);
  endtask

  task automatic set_unit(input int i, input logic [15:0] v);
    hyrja[i*16 +: 16] = v;
  endtask

  task automatic push_exp(input logic g, input logic [15:0] d);
    q.push_back({g, d});
  endtask

  // Scoreboard monitor: every handshake must match the oldest expected result.
  always @(negedge Clock) begin
    if (Reset && dalja_valid && dalja_ready) begin
      chk("sb_pending", 32'(q.size() > 0), 32'd1);
      if (q.size() > 0) begin
        logic [16:0] e;
        e = q.pop_front();
        chk("sb_dalja", 32'(dalja), 32'(e[15:0]));
        chk("sb_gabim", 32'(gabim), 32'(e[16]));
      end
    end
  end

  // Accept op, sit in WAIT, then hold reset low across two rising edges.
  task automatic reset_mid_wait(input logic [3:0] op);
    ALUOp = op; op_valid = 1'b1; dalja_ready = 1'b1;
    cyc();
    op_valid = 1'b0;
    cyc();
    Reset = 1'b0;
    cyc();
    cyc();
    mid();
    chk("rst_dalja", 32'(dalja), 32'd0);
    chk("rst_dalja_valid", 32'(dalja_valid), 32'd0);
    chk("rst_gabim", 32'(gabim), 32'd0);
    chk("rst_op_ready", 32'(op_ready), 32'd1);
    cyc();
    Reset = 1'b1;
    hyrja_valid = 4'hF;
    for (int i = 0; i < 2; i++) begin
      mid();
      chk("rst_no_stale", 32'(dalja_valid), 32'd0);
      cyc();
    end
    hyrja_valid = 4'h0;
  endtask

  initial begin
    Reset = 1'b0; hyrja = '0; hyrja_valid = '0; ALUOp = '0; op_valid = 1'b0; dalja_ready = 1'b0;
    cyc(); cyc();
    mid();
    chk("init_dalja_valid", 32'(dalja_valid), 32'd0);
    chk("init_op_ready", 32'(op_ready), 32'd1);
    cyc();
    Reset = 1'b1;

    // SLL path: unit 2 valid one cycle after accept, result at accept+2 for one cycle
    ALUOp = 4'b0110; op_valid = 1'b1; dalja_ready = 1'b1;
    mid();
    chk("t2_op_ready_idle", 32'(op_ready), 32'd1);
    cyc();
    op_valid = 1'b0; ALUOp = 4'b0000;
    set_unit(2, 16'h00F0); hyrja_valid = 4'b0100; push_exp(1'b0, 16'h00F0);
    mid();
    chk("t2_wait_op_ready", 32'(op_ready), 32'd0);
    chk("t2_valid_early", 32'(dalja_valid), 32'd0);
    cyc();
    hyrja_valid = 4'b0000; set_unit(2, 16'h0000);
    mid();
    chk("t2_valid_at_t2", 32'(dalja_valid), 32'd1);
    cyc();
    mid();
    chk("t2_valid_one_cycle", 32'(dalja_valid), 32'd0);

    // Unmapped op goes to unit 0; unit 3 valid alone is ignored
    cyc();
    ALUOp = 4'b1010; op_valid = 1'b1;
    cyc();
    op_valid = 1'b0;
    set_unit(3, 16'hBEEF); hyrja_valid = 4'b1000;
    cyc();
    mid();
    chk("t3_other_unit_ignored", 32'(dalja_valid), 32'd0);
    cyc();
    set_unit(0, 16'h1234); hyrja_valid = 4'b1001; push_exp(1'b0, 16'h1234);
    cyc();
    hyrja_valid = 4'b0000;
    mid();
    chk("t3_valid", 32'(dalja_valid), 32'd1);
    cyc();

    // SRA with unit 3 silent: timeout result at accept+17
    ALUOp = 4'b0111; op_valid = 1'b1; push_exp(1'b1, 16'h0000);
    cyc();
    op_valid = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      mid();
      chk("t4a_no_early_valid", 32'(dalja_valid), 32'd0);
      cyc();
    end
    mid();
    chk("t4a_timeout_valid", 32'(dalja_valid), 32'd1);
    chk("t4a_timeout_gabim", 32'(gabim), 32'd1);
    cyc();

    // Reset mid-WAIT with gabim still set from the timeout
    reset_mid_wait(4'b0111);

    // Unit 3 valid on the final cycle beats the timeout
    ALUOp = 4'b0111; op_valid = 1'b1; push_exp(1'b0, 16'h5A5A);
    cyc();
    op_valid = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      mid();
      chk("t4b_no_early_valid", 32'(dalja_valid), 32'd0);
      cyc();
    end
    set_unit(3, 16'h5A5A); hyrja_valid = 4'b1000;
    cyc();
    hyrja_valid = 4'b0000;
    mid();
    chk("t4b_valid", 32'(dalja_valid), 32'd1);
    chk("t4b_gabim", 32'(gabim), 32'd0);
    cyc();

    // HOLD with writeback stalled for 5 cycles while inputs churn
    ALUOp = 4'b0001; op_valid = 1'b1; dalja_ready = 1'b0;
    cyc();
    op_valid = 1'b0;
    set_unit(1, 16'h0011); hyrja_valid = 4'b0010; push_exp(1'b0, 16'h0011);
    cyc();
    for (int i = 0; i < 5; i++) begin
      ALUOp = 4'(i * 3 + 1); op_valid = 1'b1; hyrja_valid = 4'hF;
      hyrja = {16'(i * 7 + 1), 16'(i + 9), 16'hA5A5 ^ 16'(i), 16'(i * 257)};
      mid();
      chk("t5_hold_dalja", 32'(dalja), 32'h0011);
      chk("t5_hold_op_ready", 32'(op_ready), 32'd0);
      chk("t5_hold_valid", 32'(dalja_valid), 32'd1);
      cyc();
    end
    op_valid = 1'b0; hyrja_valid = 4'h0; dalja_ready = 1'b1;
    cyc();
    mid();
    chk("t5_released", 32'(dalja_valid), 32'd0);
    cyc();

    // Back-to-back: second op accepted in the handshake cycle of the first
    ALUOp = 4'b0001; op_valid = 1'b1; dalja_ready = 1'b0;
    cyc();
    op_valid = 1'b0;
    set_unit(1, 16'h0101); hyrja_valid = 4'b0010; push_exp(1'b0, 16'h0101);
    cyc();
    hyrja_valid = 4'b0000;
    mid();
    chk("t6_hold_op_ready", 32'(op_ready), 32'd0);
    cyc();
    dalja_ready = 1'b1; ALUOp = 4'b0000; op_valid = 1'b1;
    mid();
    chk("t6_handshake_op_ready", 32'(op_ready), 32'd1);
    cyc();
    op_valid = 1'b0;
    set_unit(0, 16'h0F0F); hyrja_valid = 4'b0001; push_exp(1'b0, 16'h0F0F);
    mid();
    chk("t6_second_in_wait", 32'(op_ready), 32'd0);
    chk("t6_no_bubble_valid", 32'(dalja_valid), 32'd0);
    cyc();
    hyrja_valid = 4'b0000;
    mid();
    chk("t6_second_valid", 32'(dalja_valid), 32'd1);
    cyc();

    // Reset mid-WAIT clears a nonzero dalja
    reset_mid_wait(4'b0110);

    chk("sb_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
